// File: rtl/ws2812b_run_arbiter.sv
// Shares one WS2812B serializer between two run requesters. Whole frames (runs up
// to and including a latched run) are granted round-robin; a timeout breaks stale locks.
module ws2812b_run_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [23:0] req0_color,
    input  logic [5:0]  req0_count,
    input  logic        req0_latch,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_color,
    input  logic [5:0]  req1_count,
    input  logic        req1_latch,
    output logic        req1_ready,
    output logic [23:0] led_data,
    output logic        led_valid,
    output logic        led_latch,
    input  logic        led_ready,
    output logic        busy,
    output logic        owner_valid,
    output logic        owner
);
    localparam int unsigned REM_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [23:0]        color_q, color_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic               latch_q, latch_d;
    logic               owner_q, owner_d;
    logic               owner_valid_q, owner_valid_d;
    logic               last_q, last_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               wlo_q, wlo_d;
    logic               ready0_q, ready0_d;
    logic               ready1_q, ready1_d;
    logic               led_valid_q, led_valid_d;
    logic               led_latch_q, led_latch_d;
    logic               busy_q, busy_d;

    logic               own_req;
    logic               to_expire;
    logic               grant;
    logic               grant_idx;

    assign own_req   = owner_q ? req1_valid : req0_valid;
    assign to_expire = (TIMEOUT_CYCLES != 0) && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state, grant and registered-output decode
    always_comb begin
        state_d       = state_q;
        color_d       = color_q;
        remaining_d   = remaining_q;
        latch_d       = latch_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        last_d        = last_q;
        to_d          = to_q;
        wlo_d         = 1'b0;
        ready0_d      = 1'b0;
        ready1_d      = 1'b0;
        grant         = 1'b0;
        grant_idx     = 1'b0;

        case (state_q)
            IDLE: begin
                if (owner_valid_q) begin
                    grant     = own_req && led_ready;
                    grant_idx = owner_q;
                end else if (led_ready) begin
                    if (req0_valid && req1_valid) begin
                        grant     = 1'b1;
                        grant_idx = ~last_q;
                    end else if (req0_valid) begin
                        grant     = 1'b1;
                        grant_idx = 1'b0;
                    end else if (req1_valid) begin
                        grant     = 1'b1;
                        grant_idx = 1'b1;
                    end
                end

                // Lock timeout only counts while the owner has nothing pending
                if (!owner_valid_q || own_req) begin
                    to_d = '0;
                end else if (to_expire) begin
                    owner_valid_d = 1'b0;
                    to_d          = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end

                if (grant) begin
                    state_d       = EMIT;
                    color_d       = grant_idx ? req1_color : req0_color;
                    remaining_d   = REM_W'(grant_idx ? req1_count : req0_count) + REM_W'(1);
                    latch_d       = grant_idx ? req1_latch : req0_latch;
                    owner_d       = grant_idx;
                    owner_valid_d = 1'b1;
                    last_d        = grant_idx;
                    to_d          = '0;
                    ready0_d      = ~grant_idx;
                    ready1_d      = grant_idx;
                end
            end
            EMIT: begin
                if (led_ready) begin
                    remaining_d = remaining_q - REM_W'(1);
                    state_d     = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // Serializers that never drop ready are tolerated after one extra cycle
                if (!led_ready || wlo_q) begin
                    state_d = WAIT_HI;
                end else begin
                    wlo_d = 1'b1;
                end
            end
            WAIT_HI: begin
                if (led_ready) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                        if (latch_q) begin
                            owner_valid_d = 1'b0;
                        end
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        led_valid_d = (state_d == EMIT);
        led_latch_d = (state_d == EMIT) && latch_d && (remaining_d == REM_W'(1));
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            color_q       <= '0;
            remaining_q   <= '0;
            latch_q       <= 1'b0;
            owner_q       <= 1'b0;
            owner_valid_q <= 1'b0;
            last_q        <= 1'b1;
            to_q          <= '0;
            wlo_q         <= 1'b0;
            ready0_q      <= 1'b0;
            ready1_q      <= 1'b0;
            led_valid_q   <= 1'b0;
            led_latch_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            color_q       <= color_d;
            remaining_q   <= remaining_d;
            latch_q       <= latch_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            last_q        <= last_d;
            to_q          <= to_d;
            wlo_q         <= wlo_d;
            ready0_q      <= ready0_d;
            ready1_q      <= ready1_d;
            led_valid_q   <= led_valid_d;
            led_latch_q   <= led_latch_d;
            busy_q        <= busy_d;
        end
    end

    assign req0_ready  = ready0_q;
    assign req1_ready  = ready1_q;
    assign led_data    = color_q;
    assign led_valid   = led_valid_q;
    assign led_latch   = led_latch_q;
    assign busy        = busy_q;
    assign owner_valid = owner_valid_q;
    assign owner       = owner_q;

endmodule

// File: doc/ws2812b_run_arbiter.md
Name: ws2812b_run_arbiter

Overview:
- Shares one WS2812B serializer core between two requesters, e.g. the CPU register path and a hardware animation engine.
- Each requester issues "run" commands: one 24-bit GRB colour repeated N pixels, with an optional latch on the last pixel.
- The arbiter grants whole frames, meaning all runs up to and including a latched run, round-robin, so pixel streams never interleave.
- A timeout releases a frame lock held by a stalled requester.

Parameters:
- TIMEOUT_CYCLES, 4096, idle cycles an owner may hold a frame lock with no command pending; 0 disables the timeout.
- TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 command pending
- req0_color  in  24  requester 0 colour, GRB order [23:16]=G [15:8]=R [7:0]=B
- req0_count  in  6  requester 0 pixel count minus 1 (0 → 1 pixel, 63 → 64 pixels)
- req0_latch  in  1  requester 0: latch after last pixel, which ends the frame
- req0_ready  out  1  one-cycle pulse; requester 0 command accepted
- req1_valid, req1_color, req1_count, req1_latch, req1_ready: same as req0_*, for requester 1
- led_data  out  24  pixel colour to serializer
- led_valid  out  1  pixel offered to serializer
- led_latch  out  1  latch request, qualified with led_valid
- led_ready  in  1  serializer idle and able to accept a pixel
- busy  out  1  a run is in progress (state ≠ IDLE)
- owner_valid  out  1  a frame lock is held
- owner  out  1  index of the requester holding the lock

Behaviour:
- Reset, synchronous on clk when rst_n=0, regardless of state:
  - state=IDLE; all outputs 0; led_data=0.
  - owner_valid=0; last_served=1, so requester 0 wins the first tie.
  - Remaining counter and timeout counter cleared.
- A reset mid-run abandons the run; no further led_valid is issued.
- States: IDLE, EMIT, WAIT_LO, WAIT_HI.
- IDLE, acceptance rules (acceptance requires led_ready=1):
  - If owner_valid=1, only the owner is eligible.
  - Otherwise: if exactly one req valid, grant it; if both valid, grant the one ≠ last_served.
  - On grant to requester i: req{i}_ready=1 for exactly one cycle; capture color, count+1 into remaining (7 bits), latch flag.
  - Also on grant: owner←i, owner_valid←1, last_served←i, timeout counter cleared; next state EMIT.
  - A requester must hold its fields stable while valid is high. Its valid may drop the cycle after its ready pulse.
- EMIT:
  - led_valid=1; led_data=captured color; led_latch=latch_flag & (remaining==1).
  - On led_valid & led_ready: remaining−1, led_valid deasserts next cycle, go to WAIT_LO.
  - If led_ready=0, hold led_valid and its data stable.
- WAIT_LO:
  - Wait for led_ready=0; the serializer drops ready after accepting a pixel.
  - If led_ready is still 1 on the second cycle after the handshake, proceed to WAIT_HI anyway.
- WAIT_HI:
  - Wait for led_ready=1.
  - If remaining≠0, go to EMIT.
  - If remaining==0, the run is done: go to IDLE, and if latch_flag=1 set owner_valid←0 in the same cycle.
- Throughput:
  - Minimum 2 cycles between handshakes plus serializer time.
  - A new command is accepted no earlier than the first IDLE cycle after WAIT_HI completes.
- Timeout:
  - Runs only in IDLE with owner_valid=1 and the owner's valid low; resets whenever the owner issues a command.
  - When it reaches TIMEOUT_CYCLES (≠0): owner_valid←0, counter cleared. The other requester may be granted the following cycle.
- Simultaneous events:
  - If the owner's valid rises in the same cycle the timeout expires, the command wins: grant it, keep the lock.
  - A non-owner's valid is ignored while the lock is held, even when the owner is idle.
- Count arithmetic: remaining holds 1..64, so count=63 gives 64 pixels with no wrap. led_latch is asserted on exactly one pixel per latched run.

Test Plan:
- Single run: req0 color=0x00FF00, count=2, latch=1; serializer model with 10-cycle busy → 3 handshakes, all led_data=0x00FF00; led_latch only on the 3rd; req0_ready pulsed once; owner_valid ends 0.
- Frame lock: req0 issues count=0 latch=0, then req1 and req0 both valid → req0 granted again, req1 waits. req0 then issues latch=1 → next grant goes to req1.
- Round-robin tie: both valid from reset with latch=1 runs → grant order 0,1,0,1 over four runs.
- Timeout: TIMEOUT_CYCLES=16; req1 run with latch=0, then req1 idle with req0 valid → owner_valid drops 16 cycles after IDLE is entered; req0 granted the next cycle.
- Backpressure and boundary: count=63 with led_ready held low 5 cycles before each accept → exactly 64 handshakes; led_valid and led_data stable while stalled; latch only on the 64th.
- Reset mid-run: assert rst_n=0 during WAIT_HI of a 10-pixel run → next cycle all outputs 0, state IDLE; a fresh req0 command is accepted normally.
